// File: rtl/detector_seq_ctrl_if.sv
// Handshake bundle between the frame requester/result consumer and the detector sequencer.
// Frame-in and result-out travel together so both channels share one parameter set.
interface detector_seq_ctrl_if #(
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
);
  logic               in_valid;
  logic [FRAME_W-1:0] in_data;
  logic               in_ready;
  logic               res_valid;
  logic [CNT_W-1:0]   res_count;
  logic               res_ready;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_count
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_count
  );
endinterface

// File: rtl/detector_seq_ctrl.sv
// Frame sequencer for the serial sequence detector: shifts a frame MSB-first onto din,
// flushes with zeros, counts dout pulses over frame plus gap and reports the count.
module detector_seq_ctrl #(
  parameter int FRAME_W = 8,
  parameter int GAP     = 2,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  detector_seq_ctrl_if.slave  bus,
  output logic                det_din_o,
  input  logic                det_dout_i,
  output logic                busy_o
);

  // One counter serves both the bit phase and the flush phase; it must reach FRAME_W-1.
  localparam int CW = $clog2(FRAME_W + GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_GAP    = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + CNT_W'(1'b1);
    end else begin
      sat_inc = v;
    end
  endfunction

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= {FRAME_W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      res_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      res_count_q <= res_count_d;
    end
  end

  // Next-state, shifting, phase counting and match accumulation.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    res_count_d = res_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          shreg_d     = bus.in_data;
          cnt_d       = {CW{1'b0}};
          res_count_d = {CNT_W{1'b0}};
          state_d     = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        shreg_d     = {shreg_q[FRAME_W-2:0], 1'b0};
        res_count_d = sat_inc(res_count_q, det_dout_i);
        if (cnt_q == CW'(FRAME_W - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        res_count_d = sat_inc(res_count_q, det_dout_i);
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPORT: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REPORT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so no input reaches an output combinationally.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_REPORT);
  assign bus.res_count = res_count_q;
  assign busy_o        = (state_q != S_IDLE);
  assign det_din_o     = (state_q == S_SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Self-checking bench for detector_seq_ctrl: directed and randomized frames checked
// against a frame-level model (bit order, sample window, saturating count).
module tb_detector_seq_ctrl;

  logic clk;
  logic rst_n;
  logic det_din, det_dout, busy;
  logic sat_din, sat_busy;
  int   checks;
  int   errors;

  detector_seq_ctrl_if #(.FRAME_W(8), .CNT_W(4)) bus ();
  detector_seq_ctrl_if #(.FRAME_W(8), .CNT_W(2)) sbus ();

  detector_seq_ctrl #(.FRAME_W(8), .GAP(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .det_din_o(det_din), .det_dout_i(det_dout), .busy_o(busy)
  );

  detector_seq_ctrl #(.FRAME_W(8), .GAP(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave),
    .det_din_o(sat_din), .det_dout_i(1'b1), .busy_o(sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: dout samples at edge offsets 1..FRAME_W+GAP count, saturating at maxv.
  function automatic int model_count(input logic [15:0] pat, input int maxv);
    int s;
    s = 0;
    for (int j = 1; j <= 10; j++) s += int'(pat[j]);
    return (s > maxv) ? maxv : s;
  endfunction

  // Drives one frame and records what the DUT did; the calling test does the comparing.
  task automatic drive_frame(input logic [7:0] f, input logic [15:0] pat, input int hold,
                             output logic [9:0] din_seq, output int lat, output logic [3:0] cnt,
                             output int vlen, output logic stable_ok, output logic ir_seen,
                             output logic busy_ok);
    din_seq = 10'd0; lat = -1; cnt = 4'd0; vlen = 0;
    stable_ok = 1'b1; ir_seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) step();
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait: in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    bus.res_ready = (hold == 0);
    step();
    bus.in_valid = 1'b0;
    if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 10) din_seq[9-k] = det_din;
      if (busy !== ~bus.in_ready) busy_ok = 1'b0;
      det_dout = (k + 1 < 16) ? pat[k+1] : 1'b0;
      if (bus.res_valid) begin
        if (lat < 0) begin
          lat = k + 1;
          cnt = bus.res_count;
        end else if (bus.res_count !== cnt) begin
          stable_ok = 1'b0;
        end
        if (bus.in_ready) ir_seen = 1'b1;
        vlen++;
        bus.res_ready = (vlen > hold);
        if (hold > 0) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 8'hFF;
        end
      end else if (lat >= 0) begin
        break;
      end
      step();
    end
    det_dout = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    for (int e = 0; e < 2; e++) begin
      step();
      checks++;
      if ({bus.in_ready, det_din, bus.res_valid, bus.res_count, busy} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%0b din=%0b vld=%0b cnt=%0d busy=%0b required 1 0 0 0 0",
                 bus.in_ready, det_din, bus.res_valid, bus.res_count, busy);
      end
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: in_ready=%0b busy=%0b required 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_serialisation();
    logic [9:0] ds; int lat; logic [3:0] c; int vl; logic st, ir, bo;
    drive_frame(8'hB6, 16'h0000, 0, ds, lat, c, vl, st, ir, bo);
    checks++;
    if (ds !== 10'b1011011000) begin
      errors++; $display("FAIL ser_din: got %b required %b", ds, 10'b1011011000);
    end
    checks++;
    if (lat !== 11 || vl !== 1) begin
      errors++; $display("FAIL ser_timing: latency=%0d pulse=%0d required 11 1", lat, vl);
    end
    checks++;
    if (c !== 4'd0) begin
      errors++; $display("FAIL ser_count: got %0d required 0", c);
    end
    checks++;
    if (bo !== 1'b1) begin
      errors++; $display("FAIL ser_busy: busy/in_ready relation broken (%0b) required 1", bo);
    end
  endtask

  task automatic test_counting();
    logic [9:0] ds; int lat; logic [3:0] c; int vl; logic st, ir, bo;
    logic [15:0] pat; logic [7:0] f; int exp_c;
    pat = 16'd0;
    pat[3] = 1'b1; pat[6] = 1'b1; pat[10] = 1'b1; pat[11] = 1'b1; pat[12] = 1'b1;
    drive_frame(8'h3C, pat, 0, ds, lat, c, vl, st, ir, bo);
    checks++;
    if (c !== 4'd3) begin
      errors++; $display("FAIL count_directed: got %0d required 3", c);
    end
    for (int it = 0; it < 6; it++) begin
      f = 8'($urandom);
      pat = 16'($urandom);
      exp_c = model_count(pat, 15);
      drive_frame(f, pat, 0, ds, lat, c, vl, st, ir, bo);
      checks++;
      if (ds !== {f, 2'b00} || int'(c) !== exp_c || lat !== 11) begin
        errors++;
        $display("FAIL count_random%0d: din=%b cnt=%0d lat=%0d required din=%b cnt=%0d lat=11",
                 it, ds, c, lat, {f, 2'b00}, exp_c, lat);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [9:0] ds; int lat; logic [3:0] c; int vl; logic st, ir, bo;
    logic [15:0] pat;
    pat = 16'h0244;
    drive_frame(8'h5A, pat, 5, ds, lat, c, vl, st, ir, bo);
    checks++;
    if (vl !== 6 || st !== 1'b1 || int'(c) !== model_count(pat, 15)) begin
      errors++;
      $display("FAIL bp_hold: valid_cycles=%0d stable=%0b cnt=%0d required 6 1 %0d",
               vl, st, c, model_count(pat, 15));
    end
    checks++;
    if (ir !== 1'b0) begin
      errors++; $display("FAIL bp_ignore: in_ready seen high in REPORT=%0b required 0", ir);
    end
    drive_frame(8'hFF, 16'h0000, 0, ds, lat, c, vl, st, ir, bo);
    checks++;
    if (ds !== 10'b1111111100 || lat !== 11) begin
      errors++; $display("FAIL bp_next: din=%b lat=%0d required %b 11", ds, lat, 10'b1111111100);
    end
  endtask

  task automatic test_saturation();
    int lat;
    lat = -1;
    for (int i = 0; i < 50 && !sbus.in_ready; i++) step();
    sbus.in_valid  = 1'b1;
    sbus.in_data   = 8'($urandom);
    sbus.res_ready = 1'b1;
    step();
    sbus.in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (sbus.res_valid) begin
        lat = k + 1;
        break;
      end
      step();
    end
    checks++;
    if (lat !== 11 || sbus.res_count !== 2'd3) begin
      errors++; $display("FAIL sat_count: cnt=%0d lat=%0d required 3 11", sbus.res_count, lat);
    end
    step();
    sbus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [9:0] ds; int lat; logic [3:0] c; int vl; logic st, ir, bo; int seen;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    det_dout     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    det_dout = 1'b0;
    checks++;
    if ({bus.in_ready, det_din, bus.res_valid, bus.res_count, busy} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_outputs: rdy=%0b din=%0b vld=%0b cnt=%0d busy=%0b required 1 0 0 0 0",
               bus.in_ready, det_din, bus.res_valid, bus.res_count, busy);
    end
    seen = 0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (bus.res_valid) seen++;
      step();
    end
    bus.res_ready = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_result: res_valid cycles=%0d required 0", seen);
    end
    drive_frame(8'hB6, 16'h0000, 0, ds, lat, c, vl, st, ir, bo);
    checks++;
    if (ds !== 10'b1011011000 || lat !== 11 || vl !== 1 || c !== 4'd0) begin
      errors++;
      $display("FAIL midrst_next: din=%b lat=%0d pulse=%0d cnt=%0d required %b 11 1 0",
               ds, lat, vl, c, 10'b1011011000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    det_dout = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = 8'h00;  bus.res_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = 8'h00; sbus.res_ready = 1'b0;
    test_reset();
    test_serialisation();
    test_counting();
    test_back_pressure();
    test_saturation();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
